// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared decode encodings and the packed control bundle for the ID-stage pipeline controller.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SLTU  = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_ORI   = 3'b101;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  localparam logic [1:0] BTYPE_BEQ = 2'b00;
  localparam logic [1:0] BTYPE_BNE = 2'b01;

  typedef struct packed {
    logic       regWrite;
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic [1:0] bType;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef enum logic [0:0] {ST_RUN, ST_STALL} state_t;

  // Instructions whose rt field is a source operand (and so can hit a load-use hazard).
  function automatic logic usesRt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the pipeline controller.
interface pipe_ctrl_unit_if #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3
) ();
  logic               id_valid_i;
  logic [31:0]        instr_i;
  logic               branch_taken_i;
  logic               pc_write_o;
  logic               ifid_write_o;
  logic               ifid_flush_o;
  logic               ex_valid_o;
  logic               ex_reg_write_o;
  logic               ex_alu_src_o;
  logic               ex_reg_dst_o;
  logic               ex_branch_o;
  logic               ex_mem_read_o;
  logic               ex_mem_write_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic [1:0]         ex_mem_to_reg_o;
  logic [1:0]         ex_branch_type_o;
  logic               ex_jump_o;
  logic [REG_W-1:0]   ex_rs_o;
  logic [REG_W-1:0]   ex_rt_o;
  logic [REG_W-1:0]   ex_rd_o;
  logic               ex_illegal_o;

  modport master (
    output id_valid_i, instr_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, ex_valid_o, ex_reg_write_o,
           ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_mem_read_o, ex_mem_write_o,
           ex_alu_op_o, ex_mem_to_reg_o, ex_branch_type_o, ex_jump_o,
           ex_rs_o, ex_rt_o, ex_rd_o, ex_illegal_o
  );

  modport slave (
    input  id_valid_i, instr_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, ex_valid_o, ex_reg_write_o,
           ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_mem_read_o, ex_mem_write_o,
           ex_alu_op_o, ex_mem_to_reg_o, ex_branch_type_o, ex_jump_o,
           ex_rs_o, ex_rt_o, ex_rd_o, ex_illegal_o
  );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Pure opcode -> control-bundle decode. j/jal decode only when PIPE_CTRL_JUMP_EN is defined.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OP_RTYPE: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALUOP_RTYPE; ctrl.regDst = 1'b1; end
      OP_ADDI:  begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALUOP_ADD;  ctrl.aluSrc = 1'b1; end
      OP_SLTIU: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALUOP_SLTU; ctrl.aluSrc = 1'b1; end
      OP_BEQ:   begin ctrl.aluOp = ALUOP_SUB; ctrl.branch = 1'b1; ctrl.bType = BTYPE_BEQ; end
      OP_BNE:   begin ctrl.aluOp = ALUOP_SUB; ctrl.branch = 1'b1; ctrl.bType = BTYPE_BNE; end
      OP_LUI:   begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALUOP_LUI; ctrl.aluSrc = 1'b1; end
      OP_ORI:   begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALUOP_ORI; ctrl.aluSrc = 1'b1; end
      OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = MEM_TO_REG_MEM;
      end
      OP_SW:    begin ctrl.aluOp = ALUOP_ADD; ctrl.aluSrc = 1'b1; ctrl.memWrite = 1'b1; end
`ifdef PIPE_CTRL_JUMP_EN
      OP_J:     ctrl.jump = 1'b1;
      OP_JAL:   begin ctrl.jump = 1'b1; ctrl.regWrite = 1'b1; ctrl.memToReg = MEM_TO_REG_PC4; end
`endif
      default:  ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage controller: decode into ID/EX, load-use stall FSM, branch flush.
// Optional j/jal support is enabled by defining PIPE_CTRL_JUMP_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 3,
  parameter int STALL_CYC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_ctrl_unit_if.slave  bus
);

  localparam logic [1:0] STALL_LOAD = 2'(STALL_CYC - 1);

  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] idRs, idRt, idRd, idRdEff;
  ctrl_t            idCtrl;

  assign opcode = bus.instr_i[31 -: OP_W];
  assign idRs   = bus.instr_i[25:21];
  assign idRt   = bus.instr_i[20:16];
  assign idRd   = bus.instr_i[15:11];

  ctrl_decode uDecode (
    .opcode (opcode),
    .ctrl   (idCtrl)
  );

  state_t           stateReg, stateNext;
  logic [1:0]       cntReg, cntNext;
  logic             exValidReg;
  ctrl_t            exCtrlReg;
  logic [REG_W-1:0] exRsReg, exRtReg, exRdReg;
  logic             hazard, latchBubble, pcWrite, ifidWrite, ifidFlush;

`ifdef PIPE_CTRL_JUMP_EN
  // jal links into $ra regardless of the encoded rd field.
  assign idRdEff = (opcode == OP_JAL) ? '1 : idRd;
  logic unusedInstrBits;
  assign unusedInstrBits = &{1'b0, bus.instr_i[10:0]};
`else
  assign idRdEff = idRd;
  logic unusedBits;
  assign unusedBits = &{1'b0, bus.instr_i[10:0], exCtrlReg.jump};
`endif

  assign hazard = bus.id_valid_i & exValidReg & exCtrlReg.memRead & (exRtReg != '0)
                & ((exRtReg == idRs) | ((exRtReg == idRt) & usesRt(opcode)));

  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    latchBubble = 1'b0;
    if (rst_i) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else if (bus.branch_taken_i) begin
      ifidFlush   = 1'b1;
      latchBubble = 1'b1;
      stateNext   = ST_RUN;
      cntNext     = '0;
    end else begin
      case (stateReg)
        ST_RUN: begin
          if (hazard) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            latchBubble = 1'b1;
            // A single bubble already clears the condition; longer stalls need the counter.
            if (STALL_CYC > 1) begin
              stateNext = ST_STALL;
              cntNext   = STALL_LOAD;
            end
          end else if (!bus.id_valid_i) begin
            latchBubble = 1'b1;
          end
        end
        ST_STALL: begin
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          latchBubble = 1'b1;
          cntNext     = cntReg - 2'd1;
          if (cntReg == 2'd1) stateNext = ST_RUN;
        end
        default: stateNext = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg   <= ST_RUN;
      cntReg     <= '0;
      exValidReg <= 1'b0;
      exCtrlReg  <= CTRL_NONE;
      exRsReg    <= '0;
      exRtReg    <= '0;
      exRdReg    <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (latchBubble) begin
        exValidReg <= 1'b0;
        exCtrlReg  <= CTRL_NONE;
        exRsReg    <= '0;
        exRtReg    <= '0;
        exRdReg    <= '0;
      end else begin
        exValidReg <= 1'b1;
        exCtrlReg  <= idCtrl;
        exRsReg    <= idRs;
        exRtReg    <= idRt;
        exRdReg    <= idRdEff;
      end
    end
  end

  assign bus.pc_write_o       = pcWrite;
  assign bus.ifid_write_o     = ifidWrite;
  assign bus.ifid_flush_o     = ifidFlush;
  assign bus.ex_valid_o       = exValidReg;
  assign bus.ex_reg_write_o   = exCtrlReg.regWrite;
  assign bus.ex_alu_src_o     = exCtrlReg.aluSrc;
  assign bus.ex_reg_dst_o     = exCtrlReg.regDst;
  assign bus.ex_branch_o      = exCtrlReg.branch;
  assign bus.ex_mem_read_o    = exCtrlReg.memRead;
  assign bus.ex_mem_write_o   = exCtrlReg.memWrite;
  assign bus.ex_alu_op_o      = exCtrlReg.aluOp;
  assign bus.ex_mem_to_reg_o  = exCtrlReg.memToReg;
  assign bus.ex_branch_type_o = exCtrlReg.bType;
  assign bus.ex_illegal_o     = exCtrlReg.illegal;
  assign bus.ex_rs_o          = exRsReg;
  assign bus.ex_rt_o          = exRtReg;
  assign bus.ex_rd_o          = exRdReg;
`ifdef PIPE_CTRL_JUMP_EN
  assign bus.ex_jump_o        = exCtrlReg.jump;
`else
  assign bus.ex_jump_o        = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Two controllers (1- and 2-cycle load-use stall) driven in lockstep and checked against a queue-free behavioural model.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic [1:0] bType;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic       jump;
    logic       illegal;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idValid = 1'b0;
  logic        br = 1'b0;
  logic [31:0] instr = '0;
  int          total = 0;
  int          bad = 0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if b1 ();
  pipe_ctrl_unit_if b2 ();

  assign b1.id_valid_i = idValid;  assign b2.id_valid_i = idValid;
  assign b1.instr_i = instr;       assign b2.instr_i = instr;
  assign b1.branch_taken_i = br;   assign b2.branch_taken_i = br;

  pipe_ctrl_unit #(.STALL_CYC(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  pipe_ctrl_unit #(.STALL_CYC(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  exp_t       dutEx[2];
  logic [2:0] dutComb[2];

  assign dutEx[0] = {b1.ex_valid_o, b1.ex_reg_write_o, b1.ex_alu_op_o, b1.ex_alu_src_o,
                     b1.ex_reg_dst_o, b1.ex_branch_o, b1.ex_branch_type_o, b1.ex_mem_read_o,
                     b1.ex_mem_write_o, b1.ex_mem_to_reg_o, b1.ex_jump_o, b1.ex_illegal_o,
                     b1.ex_rs_o, b1.ex_rt_o, b1.ex_rd_o};
  assign dutEx[1] = {b2.ex_valid_o, b2.ex_reg_write_o, b2.ex_alu_op_o, b2.ex_alu_src_o,
                     b2.ex_reg_dst_o, b2.ex_branch_o, b2.ex_branch_type_o, b2.ex_mem_read_o,
                     b2.ex_mem_write_o, b2.ex_mem_to_reg_o, b2.ex_jump_o, b2.ex_illegal_o,
                     b2.ex_rs_o, b2.ex_rt_o, b2.ex_rd_o};
  assign dutComb[0] = {b1.pc_write_o, b1.ifid_write_o, b1.ifid_flush_o};
  assign dutComb[1] = {b2.pc_write_o, b2.ifid_write_o, b2.ifid_flush_o};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference decode straight from the instruction table.
  function automatic exp_t refDecode(input logic [31:0] ins);
    exp_t e;
    e = '0;
    e.valid = 1'b1;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = ins[15:11];
    case (ins[31:26])
      6'h00: begin e.regWrite = 1; e.regDst = 1; end
      6'h08: begin e.regWrite = 1; e.aluOp = 3'd1; e.aluSrc = 1; end
      6'h0b: begin e.regWrite = 1; e.aluOp = 3'd2; e.aluSrc = 1; end
      6'h04: begin e.aluOp = 3'd3; e.branch = 1; end
      6'h05: begin e.aluOp = 3'd3; e.branch = 1; e.bType = 2'b01; end
      6'h0f: begin e.regWrite = 1; e.aluOp = 3'd4; e.aluSrc = 1; end
      6'h0d: begin e.regWrite = 1; e.aluOp = 3'd5; e.aluSrc = 1; end
      6'h23: begin e.regWrite = 1; e.aluOp = 3'd1; e.aluSrc = 1; e.memRead = 1; e.memToReg = 2'b01; end
      6'h2b: begin e.aluOp = 3'd1; e.aluSrc = 1; e.memWrite = 1; end
`ifdef PIPE_CTRL_JUMP_EN
      6'h02: e.jump = 1;
      6'h03: begin e.jump = 1; e.regWrite = 1; e.memToReg = 2'b10; e.rd = 5'd31; end
`endif
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  // Model state: what ID/EX holds, and how many more forced bubbles are owed.
  exp_t mEx[2];
  int   mOwed[2];
  initial begin
    mEx[0] = '0; mEx[1] = '0; mOwed[0] = 0; mOwed[1] = 0;
  end

  always @(negedge clk) begin
    logic [2:0] expComb;
    exp_t       nxt;
    logic [5:0] op;
    bit         hz;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        op = instr[31:26];
        hz = idValid && mEx[k].valid && mEx[k].memRead && (mEx[k].rt != 0) &&
             ((mEx[k].rt == instr[25:21]) ||
              ((mEx[k].rt == instr[20:16]) && (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b)));
        if (rst) begin
          expComb = 3'b000; nxt = '0; mOwed[k] = 0;
        end else if (br) begin
          expComb = 3'b111; nxt = '0; mOwed[k] = 0;
        end else if (mOwed[k] > 0) begin
          expComb = 3'b000; nxt = '0; mOwed[k] = mOwed[k] - 1;
        end else if (hz) begin
          expComb = 3'b000; nxt = '0; mOwed[k] = k;  // total bubbles = k+1
        end else begin
          expComb = 3'b110; nxt = idValid ? refDecode(instr) : '0;
        end
        check($sformatf("comb_dut%0d", k + 1), 64'(dutComb[k]), 64'(expComb));
        check($sformatf("idex_dut%0d", k + 1), 64'(dutEx[k]), 64'(mEx[k]));
        mEx[k] = nxt;
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [31:0] i, input logic b);
    @(posedge clk);
    #1;
    rst = r; idValid = v; instr = i; br = b;
    @(negedge clk);
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] op;
    case ($urandom_range(0, 13))
      0, 1:    op = 6'h23;
      2, 3:    op = 6'h00;
      4:       op = 6'h08;
      5:       op = 6'h0b;
      6:       op = 6'h04;
      7:       op = 6'h05;
      8:       op = 6'h0f;
      9:       op = 6'h0d;
      10:      op = 6'h2b;
      11:      op = 6'h02;
      12:      op = 6'h03;
      default: op = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  localparam logic [31:0] LW2    = {6'h23, 5'd1, 5'd2, 16'd0};
  localparam logic [31:0] ADD324 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADDI53 = {6'h08, 5'd3, 5'd5, 16'd4};
  localparam logic [31:0] LW0    = {6'h23, 5'd1, 5'd0, 16'd0};
  localparam logic [31:0] ADD300 = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ILL    = {6'h3f, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] JAL    = {6'h03, 26'h0000123};

  initial begin
    exp_t litEx;
    @(posedge clk);
    #1;
    started = 1'b1;
    step(1, 0, 0, 0);
    check("reset_idex", 64'(dutEx[1]), 64'd0);
    check("reset_pcwrite", 64'(dutComb[1]), 64'd0);
    step(0, 0, 0, 0);

    // lw $2 then add $3,$2,$4
    step(0, 1, LW2, 0);
    step(0, 1, ADD324, 0);
    check("lu_s1_stall", 64'(dutComb[0][2]), 64'd0);
    check("lu_s2_stall", 64'(dutComb[1][2]), 64'd0);
    step(0, 1, ADD324, 0);
    check("lu_s1_resume", 64'(dutComb[0][2]), 64'd1);
    check("lu_s1_bubble", 64'(dutEx[0].valid), 64'd0);
    check("lu_s2_stall2", 64'(dutComb[1][2]), 64'd0);
    step(0, 1, ADD324, 0);
    check("lu_s1_add", 64'({dutEx[0].valid, dutEx[0].aluOp, dutEx[0].regDst}), 64'(5'b1_000_1));
    check("lu_s2_bubble", 64'(dutEx[1].valid), 64'd0);
    check("lu_s2_resume", 64'(dutComb[1][2]), 64'd1);
    step(0, 0, 0, 0);
    check("lu_s2_add", 64'({dutEx[1].valid, dutEx[1].aluOp, dutEx[1].regDst, dutEx[1].rd}),
          64'({1'b1, 3'b000, 1'b1, 5'd3}));

    // no-hazard pairs
    step(0, 1, LW2, 0);
    step(0, 1, ADDI53, 0);
    check("nohz_addi_s1", 64'(dutComb[0][2]), 64'd1);
    check("nohz_addi_s2", 64'(dutComb[1][2]), 64'd1);
    step(0, 0, 0, 0);
    step(0, 1, LW0, 0);
    step(0, 1, ADD300, 0);
    check("nohz_r0_s1", 64'(dutComb[0][2]), 64'd1);
    check("nohz_r0_s2", 64'(dutComb[1][2]), 64'd1);
    step(0, 0, 0, 0);

    // flush during second stall cycle
    step(0, 1, LW2, 0);
    step(0, 1, ADD324, 0);
    step(0, 1, ADD324, 1);
    check("flush_comb", 64'(dutComb[1]), 64'(3'b111));
    step(0, 0, 0, 0);
    check("flush_bubble", 64'(dutEx[1].valid), 64'd0);
    check("flush_run", 64'(dutComb[1][2]), 64'd1);
    step(0, 0, 0, 0);
    check("flush_nostall", 64'(dutComb[1][2]), 64'd1);

    // reset in the middle of a stall
    step(0, 1, LW2, 0);
    step(0, 1, ADD324, 0);
    step(1, 1, ADD324, 0);
    check("rststall_comb", 64'(dutComb[1]), 64'd0);
    step(0, 0, 0, 0);
    check("rststall_idex", 64'(dutEx[1]), 64'd0);
    check("rststall_pc", 64'(dutComb[1][2]), 64'd1);

    // illegal opcode and jal
    step(0, 1, ILL, 0);
    step(0, 1, JAL, 0);
    litEx = {1'b1, 13'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3};
    check("illegal", 64'(dutEx[0]), 64'(litEx));
    step(0, 0, 0, 0);
`ifdef PIPE_CTRL_JUMP_EN
    check("jal", 64'({dutEx[0].jump, dutEx[0].rd, dutEx[0].memToReg, dutEx[0].illegal}),
          64'({1'b1, 5'd31, 2'b10, 1'b0}));
`else
    check("jal_off", 64'({dutEx[0].jump, dutEx[0].illegal}), 64'(2'b01));
`endif

    repeat (3000) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), randInstr(),
           ($urandom_range(0, 11) == 0));
    end
    step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined successor to the single-cycle main-control decoder. It sits in the ID stage of the 5-stage MIPS datapath. Each cycle it decodes the IF/ID instruction and registers the full control bundle into the ID/EX boundary. It also owns load-use hazard detection, a parametrised multi-cycle stall counter, and branch flush / bubble insertion.

Parameters:
OP_W, 6, opcode width
REG_W, 5, register-address width
ALUOP_W, 3, ALU_op field width
STALL_CYC, 1, load-use stall length in cycles; 1 with MEM→EX forwarding, 2 without; legal range 1..3

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  IF/ID holds a real instruction
instr_i  in  32  IF/ID instruction
branch_taken_i  in  1  EX resolved a taken branch this cycle
pc_write_o  out  1  PC enable (comb)
ifid_write_o  out  1  IF/ID enable (comb)
ifid_flush_o  out  1  IF/ID clear (comb)
ex_valid_o  out  1  ID/EX holds a real instruction
ex_reg_write_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_mem_read_o, ex_mem_write_o  out  1 each  registered controls
ex_alu_op_o  out  ALUOP_W  registered ALU op
ex_mem_to_reg_o  out  2  registered writeback select
ex_branch_type_o  out  2  00 beq, 01 bne
ex_jump_o  out  1  active-high jump
ex_rs_o, ex_rt_o, ex_rd_o  out  REG_W each  registered register fields
ex_illegal_o  out  1  registered: unknown opcode decoded

Behaviour:
- Reset (rst_i=1 at edge): every ex_* output = 0, FSM → RUN, cnt = 0. While rst_i=1, pc_write_o = ifid_write_o = ifid_flush_o = 0.
- Decode table, giving {reg_write, alu_op, alu_src, reg_dst, branch, btype, mem_read, mem_write, mem_to_reg}:
  - R 000000: 1, 000, 0, 1, 0, 00, 0, 0, 00
  - addi 001000: 1, 001, 1, 0, 0, 00, 0, 0, 00
  - sltiu 001011: 1, 010, 1, 0, 0, 00, 0, 0, 00
  - beq 000100: 0, 011, 0, 0, 1, 00, 0, 0, 00
  - bne 000101: 0, 011, 0, 0, 1, 01, 0, 0, 00
  - lui 001111: 1, 100, 1, 0, 0, 00, 0, 0, 00
  - ori 001101: 1, 101, 1, 0, 0, 00, 0, 0, 00
  - lw 100011: 1, 001, 1, 0, 0, 00, 1, 0, 01
  - sw 101011: 0, 001, 1, 0, 0, 00, 0, 1, 00
  - Any other opcode: all controls 0, illegal=1.
- Latency: instr_i decoded in cycle N appears on ex_* after edge N+1. Register fields are taken as rs=[25:21], rt=[20:16], rd=[15:11].
- Bubble: ex_valid = 0, all controls = 0, illegal = 0. Register fields are don't-care, but are driven 0.
- Hazard condition: ex_valid_o & ex_mem_read_o & ex_rt_o≠0 & (ex_rt_o==rs | (ex_rt_o==rt & instr uses rt)). Opcodes that use rt are R, beq, bne, sw. The condition applies only when id_valid_i=1.
- FSM RUN:
  - Hazard: pc_write_o = ifid_write_o = 0 and a bubble is latched.
  - If STALL_CYC > 1: go to STALL with cnt = STALL_CYC-1.
  - Otherwise: stay in RUN, since the bubble clears the condition.
  - No hazard: enables = 1, decode latched, ex_valid = id_valid_i.
- FSM STALL: pc_write_o = ifid_write_o = 0, bubble latched, cnt decrements each cycle. When cnt==1, go to RUN on the next edge.
- Flush (branch_taken_i=1) has top priority in any state:
  - ifid_flush_o = 1, pc_write_o = 1, ifid_write_o = 1.
  - A bubble is latched; FSM → RUN, cnt = 0.
  - The pending stall is abandoned.
- id_valid_i=0 in RUN: bubble latched, no stall raised.
- Reset has priority over flush and stall.

Optional Feature:
- Macro: PIPE_CTRL_JUMP_EN.
- When defined:
  - j 000010 decodes with jump=1 and all other controls 0.
  - jal 000011 decodes with jump=1, reg_write=1, mem_to_reg=10 and rd forced to 31 on ex_rd_o.
- When undefined: both opcodes decode as illegal and ex_jump_o is tied to 0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE … OP_JAL)
  - ALU_op encodings (ALUOP_RTYPE=000 … ALUOP_ORI=101)
  - MEM_TO_REG encodings (ALU=00, MEM=01, PC4=10)
  - BTYPE encodings
  - a packed ctrl_t struct
- Sub-module ctrl_decode holds the pure combinational decode from opcode to ctrl_t. The top level holds the hazard logic, FSM, counter and ID/EX register.

Test Plan:
- Reset asserted mid-stall (STALL_CYC=2, cnt=1) → next cycle all ex_* = 0, FSM RUN, pc_write_o=1 after release.
- lw $2,0($1) then add $3,$2,$4 with STALL_CYC=1 → one cycle of pc_write_o=0, one bubble, then add appears with alu_op=000 and reg_dst=1.
- Same pair with STALL_CYC=2 → two stall cycles, two bubbles, add latched on the third edge.
- lw $2 followed by addi $5,$3,4 (rt=$5 is not a source) → no stall. Also lw $0 followed by add $3,$0,$0 → no stall.
- branch_taken_i=1 during the second cycle of a 2-cycle stall → ifid_flush_o=1, bubble latched, RUN next, no further stall.
- Opcode 111111 → ex_illegal_o=1 and all controls 0. With PIPE_CTRL_JUMP_EN, jal → ex_jump_o=1, ex_rd_o=31, ex_mem_to_reg_o=10.
